io_handshake_unit: RTL

- Responder for the control unit's input_flag, output_flag and halt strobes.
- Input: holds the processor stalled until the user presses the debounced enter button, then presents the switch value for one register-write cycle.
- Output: latches the register value into a display register.
- Halt: freezes the processor until reset.
- Sits between the control unit/datapath and board switches, button and displays.

---
 rtl/io_handshake_unit.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/io_handshake_unit.sv
// -----------------------------------------------------------------------------
// io_handshake_unit
// Responds to the control unit's Input, Output and HALT strobes. An Input
// stalls the processor until the user presses the debounced enter button,
// then offers the synchronised switch value for one register-write cycle.
// An Output latches the register value into the display register. A HALT
// freezes the processor until reset.
//
// Optional feature (macro IO_OUTPUT_WAIT_EN): when defined, an Output also
// stalls the processor in an OUT_WAIT state until the user presses enter.
//
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   input_flag       current instruction is Input
//   output_flag      current instruction is Output
//   halt             current instruction is HALT
//   out_data         register value to display
//   switches         raw asynchronous user switches
//   enter_btn        raw asynchronous enter push-button, active-high
//   stall            freezes PC and register-file write (combinational)
//   in_data          zero-extended synchronised switches
//   in_valid         one-cycle write strobe for in_data (combinational)
//   display_value    last value output
//   display_valid    set on first output, sticky until reset
//   waiting_input    LED, high while waiting for a press
//   halted           processor halted
// -----------------------------------------------------------------------------
module io_handshake_unit #(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned SW_W            = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              input_flag,
    input  logic              output_flag,
    input  logic              halt,
    input  logic [DATA_W-1:0] out_data,
    input  logic [SW_W-1:0]   switches,
    input  logic              enter_btn,
    output logic              stall,
    output logic [DATA_W-1:0] in_data,
    output logic              in_valid,
    output logic [DATA_W-1:0] display_value,
    output logic              display_valid,
    output logic              waiting_input,
    output logic              halted
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Switch bank must fit inside the datapath word.
    generate
        if (SW_W > DATA_W) begin : g_bad_sw_w
            $error("io_handshake_unit: SW_W must not exceed DATA_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_PRESS   = 3'd1,
        ST_WAIT_RELEASE = 3'd2,
        ST_HALTED       = 3'd3
`ifdef IO_OUTPUT_WAIT_EN
        ,
        ST_OUT_WAIT     = 3'd4
`endif
    } state_e;

    // Two-flop synchronisers
    logic [SW_W-1:0] sw_meta_q;
    logic [SW_W-1:0] sw_sync_q;
    logic            btn_meta_q;
    logic            btn_sync_q;

    // Debouncer
    logic             btn_db_q;
    logic             btn_db_d;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] db_cnt_d;
    logic             press_q;
    logic             press_d;

    // FSM and display
    state_e            state_q;
    state_e            state_d;
    logic              stall_c;
    logic              in_valid_c;
    logic              disp_load_c;
    logic [DATA_W-1:0] display_value_q;
    logic              display_valid_q;

    // Synchronise the asynchronous board inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
        end else begin
            sw_meta_q  <= switches;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= enter_btn;
            btn_sync_q <= btn_meta_q;
        end
    end

    // The level only flips after DEBOUNCE_CYCLES consecutive differing samples;
    // the press strobe is raised on the same edge that btn_db rises.
    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        press_d  = 1'b0;
        if (btn_sync_q != btn_db_q) begin
            if (db_cnt_q == CNT_MAX) begin
                btn_db_d = btn_sync_q;
                press_d  = btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
    end

    // Debouncer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_db_q <= 1'b0;
            db_cnt_q <= '0;
            press_q  <= 1'b0;
        end else begin
            btn_db_q <= btn_db_d;
            db_cnt_q <= db_cnt_d;
            press_q  <= press_d;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, stall and write strobe. A press that peaks while still in
    // IDLE is a one-cycle pulse and is gone by the time WAIT_PRESS is entered.
    always_comb begin
        state_d     = state_q;
        stall_c     = 1'b0;
        in_valid_c  = 1'b0;
        disp_load_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (input_flag) begin
                    state_d = ST_WAIT_PRESS;
                    stall_c = 1'b1;
                end else if (output_flag) begin
                    disp_load_c = 1'b1;
`ifdef IO_OUTPUT_WAIT_EN
                    state_d = ST_OUT_WAIT;
`endif
                end
            end
            ST_WAIT_PRESS: begin
                if (press_q) begin
                    in_valid_c = 1'b1;
                    state_d    = ST_WAIT_RELEASE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            ST_WAIT_RELEASE: begin
                // A follow-on Input is held here until the button is released.
                stall_c = input_flag;
                if (halt) begin
                    state_d = ST_HALTED;
                end else begin
                    disp_load_c = output_flag;
                    if (!btn_db_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALTED: begin
                stall_c = 1'b1;
            end
`ifdef IO_OUTPUT_WAIT_EN
            ST_OUT_WAIT: begin
                if (press_q) begin
                    state_d = ST_WAIT_RELEASE;
                end else begin
                    stall_c = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Reset aborts a pending accept in the same cycle.
        if (reset) begin
            in_valid_c = 1'b0;
        end
    end

    // Display register, sticky valid flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            display_value_q <= '0;
            display_valid_q <= 1'b0;
        end else if (disp_load_c) begin
            display_value_q <= out_data;
            display_valid_q <= 1'b1;
        end
    end

    assign stall         = stall_c;
    assign in_valid      = in_valid_c;
    assign in_data       = DATA_W'(sw_sync_q);
    assign display_value = display_value_q;
    assign display_valid = display_valid_q;
    assign halted        = (state_q == ST_HALTED);
`ifdef IO_OUTPUT_WAIT_EN
    assign waiting_input = (state_q == ST_WAIT_PRESS) || (state_q == ST_OUT_WAIT);
`else
    assign waiting_input = (state_q == ST_WAIT_PRESS);
`endif

    // A write strobe must never coincide with a stall.
    a_valid_not_stalled : assert property (@(posedge clock) disable iff (reset)
        !(in_valid && stall));

endmodule
